stopwatch_ctrl: RTL

Sequencing controller for the stopwatch datapath. It consumes the debounced pause/reset levels, the sel/adj switches and single-cycle tick enables produced by the clock divider. It runs a RUN/PAUSED/ADJUST state machine and owns the MM:SS BCD count. It drives the digit values plus a per-digit blank mask to the seven-segment display driver.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/bcd_mod_counter.sv | 56 +++++
 rtl/stopwatch_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and constants for the stopwatch controller
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } sw_state_e;

    localparam int SEC_MOD_DEF = 60;
    localparam int MIN_MOD_DEF = 100;
    localparam int BCD_W       = 4;

    // Blank mask for a given state: only the field being adjusted blinks.
    function automatic logic [3:0] blank_mask(input sw_state_e st,
                                              input logic      phase,
                                              input logic      sel_sec);
        logic [3:0] m;
        m = 4'b0000;
        if (st == ST_ADJUST && phase) begin
            m = sel_sec ? 4'b0011 : 4'b1100;
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping at MOD-1 back to 00
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             wrap
);

    localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'((MOD - 1) / 10);
    localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'((MOD - 1) % 10);
    localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);
    localparam logic [BCD_W-1:0] ONE      = BCD_W'(1);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;
    logic             at_max;

    assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign wrap   = inc && at_max;
    assign tens   = tens_q;
    assign ones   = ones_q;

    // Next value is derived fully from legal BCD, so no illegal digit is ever stored.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == NINE) begin
                tens_d = tens_q + ONE;
                ones_d = '0;
            end else begin
                ones_d = ones_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - RUN/PAUSED/ADJUST sequencer owning the MM:SS BCD count
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SEC_MOD = SEC_MOD_DEF,
    parameter int MIN_MOD = MIN_MOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             tick_blink,
    input  logic             pause_lvl,
    input  logic             adj,
    input  logic             sel,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic [3:0]       blank,
    output logic             running
);

    sw_state_e  state_q, state_d;
    logic       paused_flag_q, paused_flag_d;
    logic       blink_q, blink_d;
    logic       pause_q;
    logic [3:0] blank_q;
    logic       running_q;

    logic       pause_evt;
    logic       sec_inc, min_inc;
    logic       sec_wrap;
    logic       min_wrap_unused;

    assign pause_evt = pause_lvl && !pause_q;

    // A pause event always flips the flag; in ADJUST it only matters on exit.
    always_comb begin
        paused_flag_d = paused_flag_q ^ pause_evt;
        blink_d       = blink_q ^ tick_blink;
        if (adj) begin
            state_d = ST_ADJUST;
        end else begin
            state_d = paused_flag_d ? ST_PAUSED : ST_RUN;
        end
    end

    // Counting action follows the current registered state, not the next one.
    always_comb begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                sec_inc = tick_1hz;
                min_inc = sec_wrap;
            end
            ST_ADJUST: begin
                sec_inc = tick_2hz && sel;
                min_inc = tick_2hz && !sel;
            end
            default: begin
                sec_inc = 1'b0;
                min_inc = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            paused_flag_q <= 1'b0;
            blink_q       <= 1'b0;
            pause_q       <= 1'b0;
            blank_q       <= 4'b0000;
            running_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            paused_flag_q <= paused_flag_d;
            blink_q       <= blink_d;
            pause_q       <= pause_lvl;
            blank_q       <= blank_mask(state_d, blink_d, sel);
            running_q     <= (state_d == ST_RUN);
        end
    end

    bcd_mod_counter #(
        .MOD (SEC_MOD)
    ) u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (sec_inc),
        .tens (sec_tens),
        .ones (sec_ones),
        .wrap (sec_wrap)
    );

    bcd_mod_counter #(
        .MOD (MIN_MOD)
    ) u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (min_inc),
        .tens (min_tens),
        .ones (min_ones),
        .wrap (min_wrap_unused)
    );

    assign blank   = blank_q;
    assign running = running_q;

endmodule
